// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads and buffers {pc, instr} for decode.
// Define BTFN_PRED_EN for static backward-taken/forward-not-taken prediction of JAL and branches.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_pred_taken
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] tag_mem   [FIFO_DEPTH];
  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [31:0] instr_mem [FIFO_DEPTH];

  logic          req_fire, push, pop, pred_taken;
  logic [31:0]   tag_pc, pred_target;
  logic [CW-1:0] in_use;

  assign tag_pc   = tag_mem[tag_rd_q];
  assign if_valid = (count_q != '0);
  assign if_pc    = pc_mem[rd_ptr_q];
  assign if_instr = instr_mem[rd_ptr_q];
  assign pop      = if_valid & if_ready & ~redirect_valid;
  assign push     = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;

  // A slot being handed to decode this cycle is already free, so streaming never bubbles.
  assign in_use         = outstanding_q + count_q - CW'(pop);
  assign imem_req_valid = (state_q != ST_IDLE) & ~redirect_valid & (in_use < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

`ifdef BTFN_PRED_EN
  logic        is_jal, is_bneg;
  logic [31:0] imm_j, imm_b;
  logic        pred_mem [FIFO_DEPTH];

  always_comb begin
    is_jal      = (imem_rsp_data[6:0] == 7'b1101111);
    is_bneg     = (imem_rsp_data[6:0] == 7'b1100011) & imem_rsp_data[31];
    imm_j       = {{12{imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
                   imem_rsp_data[30:21], 1'b0};
    imm_b       = {{20{imem_rsp_data[31]}}, imem_rsp_data[7], imem_rsp_data[30:25],
                   imem_rsp_data[11:8], 1'b0};
    pred_taken  = push & (is_jal | is_bneg);
    pred_target = tag_pc + (is_jal ? imm_j : imm_b);
  end

  always_ff @(posedge clk) begin
    if (push) pred_mem[wr_ptr_q] <= pred_taken;
  end

  assign if_pred_taken = if_valid & pred_mem[rd_ptr_q];
`else
  assign pred_taken    = 1'b0;
  assign pred_target   = 32'h0;
  assign if_pred_taken = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_wr_d   = tag_wr_q + AW'(1);
    end
    if (imem_rsp_valid) begin
      tag_rd_d = tag_rd_q + AW'(1);
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    // Everything fetched after the predicted instruction is on the wrong path.
    if (pred_taken) begin
      fetch_pc_d = pred_target;
      drop_cnt_d = outstanding_q - CW'(1) + CW'(req_fire);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      default: state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      pc_mem[wr_ptr_q]    <= tag_pc;
      instr_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: reset/stream vector table, hand-written backpressure, redirect and
// collision sequences, then a randomized run checked against a queue-based fetch model.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, redirect_valid = 1'b0, imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic        imem_req_valid, if_valid, if_pred_taken;
  logic [31:0] imem_req_addr, if_pc, if_instr;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_pred_taken(if_pred_taken)
  );

  int errors = 0, checks = 0;
  int unsigned cyc = 0;

  // Memory + model state: every fired request in order, with its due cycle and whether a redirect
  // has made it stale; the decode-side queue holds the PCs the DUT should be presenting.
  typedef struct { logic [31:0] pc; int unsigned due; bit stale; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] fifo_pc[$];
  logic [31:0] exp_pc = '0;
  int unsigned last_due = 0;
  int          run_cycles = 0;
  int          lat_min = 1, lat_max = 1;
  bit          use_model = 1'b1, plant_branch = 1'b0;
  int          fires = 0;
  logic        s_rv, s_iv, s_pt;
  logic [31:0] s_addr, s_pc, s_instr;

  typedef struct {
    bit r; bit ifr;
    bit exp_rv; logic [31:0] exp_addr;
    bit exp_iv; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (plant_branch && a == 32'h0000_0010) return 32'hFE00_0EE3;
    return {a[24:0] ^ 25'h1A5_5A5A, 7'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                      input bit rq_rdy, input bit ifr);
    bit          rsp, fire, pop_e, exp_rv;
    mreq_t       m;
    int unsigned due;
    @(negedge clk);
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rq_rdy;
    if_ready       = ifr;
    rsp            = (mq.size() > 0) && (mq[0].due == cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].pc) : 32'hDEAD_BEEF;
    #1;
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = if_valid;
    s_pc = if_pc; s_instr = if_instr; s_pt = if_pred_taken;
    fire  = s_rv && rq_rdy;
    pop_e = (fifo_pc.size() > 0) && ifr && !redir;
    if (fire) fires++;

    if (use_model && !r) begin
      exp_rv = (run_cycles >= 1) && !redir &&
               ((mq.size() + fifo_pc.size() - (pop_e ? 1 : 0)) < DEPTH);
      chk("model_req_valid", {31'b0, s_rv}, {31'b0, exp_rv});
      if (exp_rv) chk("model_req_addr", s_addr, exp_pc);
      chk("model_if_valid", {31'b0, s_iv}, {31'b0, fifo_pc.size() > 0});
      if (fifo_pc.size() > 0) begin
        chk("model_if_pc", s_pc, fifo_pc[0]);
        chk("model_if_instr", s_instr, mem_word(fifo_pc[0]));
      end
      chk("model_pred_taken", {31'b0, s_pt}, 32'h0);
    end
    if (!r && s_iv && ifr && !redir)
      $display("xfer cycle=%0d pc=0x%08h instr=0x%08h pred=%0b", cyc, s_pc, s_instr, s_pt);

    if (r) begin
      mq.delete(); fifo_pc.delete();
      exp_pc = 32'h0; run_cycles = 0; last_due = cyc;
    end else begin
      run_cycles++;
      if (redir) begin
        fifo_pc.delete();
        for (int i = 0; i < mq.size(); i++) mq[i].stale = 1'b1;
        exp_pc = rpc;
      end else if (pop_e) begin
        void'(fifo_pc.pop_front());
      end
      if (rsp) begin
        m = mq.pop_front();
        if (!m.stale) fifo_pc.push_back(m.pc);
      end
      if (fire) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{pc: s_addr, due: due, stale: 1'b0});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    bit          seen;
    logic [31:0] rnd;

    // Reset, idle cycle, then a latency-1 stream with decode always ready.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, 1'b0, 32'h0, 1'b1, tbl[i].ifr);
      chk("tbl_req_valid", {31'b0, s_rv}, {31'b0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) chk("tbl_req_addr", s_addr, tbl[i].exp_addr);
      chk("tbl_if_valid", {31'b0, s_iv}, {31'b0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) chk("tbl_if_pc", s_pc, tbl[i].exp_pc);
      chk("tbl_pred_taken", {31'b0, s_pt}, 32'h0);
    end

    // Backpressure: decode stalled, only DEPTH requests may be in the air or buffered.
    do_reset();
    fires = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_fires", fires, 2);
    chk("bp_hold_valid", {31'b0, s_iv}, 32'h1);
    chk("bp_hold_pc", s_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_release_pc0", s_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_release_pc4", s_pc, 32'h4);

    // Redirect with two long-latency requests outstanding.
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir_next_addr", s_addr, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_iv) begin
        seen = 1'b1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    chk("redir_seen", {31'b0, seen}, 32'h1);

    // Collision: redirect coincides with a response and a decode handshake.
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    chk("coll_pre_if_valid", {31'b0, s_iv}, 32'h1);
    chk("coll_pre_rsp", {31'b0, imem_rsp_valid}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("coll_if_valid", {31'b0, s_iv}, 32'h0);
    chk("coll_addr", s_addr, 32'h200);
    chk("coll_req_valid", {31'b0, s_rv}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("coll_first_valid", {31'b0, s_iv}, 32'h1);
    chk("coll_first_pc", s_pc, 32'h200);

`ifdef BTFN_PRED_EN
    // Backward branch at 0x10 predicted taken to 0x0C; the 0x14 fetch must vanish.
    use_model = 1'b0; plant_branch = 1'b1;
    do_reset();
    lat_min = 2; lat_max = 2;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_iv) begin
        seen = 1'b1;
        chk("btfn_br_pc", s_pc, 32'h10);
        chk("btfn_br_pred", {31'b0, s_pt}, 32'h1);
      end
    end
    chk("btfn_br_seen", {31'b0, seen}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_iv) begin
        seen = 1'b1;
        chk("btfn_target_pc", s_pc, 32'h0C);
        chk("btfn_target_pred", {31'b0, s_pt}, 32'h0);
      end
    end
    chk("btfn_target_seen", {31'b0, seen}, 32'h1);
    plant_branch = 1'b0; use_model = 1'b1;
`endif

    // Randomized traffic: variable latency, stalls on both sides, redirects incl. the 32-bit wrap.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom();
      rnd[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rnd = 32'hFFFF_FFF8;
      step(1'b0, ($urandom_range(0, 99) < 6), rnd,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
